// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: one instruction per handshake, strobes decoded from state.
// Latency accept->instr_done: 4 R/addi, 3 beq, 3+N sw, 4+N lw (N = MEM cycles); 2 for illegal opcodes.
// Backpressure: instr_ready only in IDLE. Optional retired counter under MIPS_CTRL_PERF_EN.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr_word,
    input  logic             mem_ack,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             branch,
    output logic             instr_done,
    output logic             err,
    output logic [CNT_W-1:0] retired_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
    } state_t;

    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_BEQ  = 6'd4;

    state_t         r_state, w_state_nxt;
    logic [5:0]     r_op;
    logic           r_err, w_err_nxt;
    logic [TW-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic           w_is_r, w_is_lw, w_is_sw, w_is_addi, w_is_beq, w_legal, w_lvl_en;
    logic           w_unused;

    assign w_unused  = &instr_word[25:0];
    assign w_is_r    = (r_op == OP_R);
    assign w_is_lw   = (r_op == OP_LW);
    assign w_is_sw   = (r_op == OP_SW);
    assign w_is_addi = (r_op == OP_ADDI);
    assign w_is_beq  = (r_op == OP_BEQ);
    assign w_legal   = w_is_r | w_is_lw | w_is_sw | w_is_addi | w_is_beq;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_state_nxt = S_DECODE;
                    w_err_nxt   = 1'b0;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_is_beq)               w_state_nxt = S_DONE;
                else if (w_is_lw | w_is_sw) w_state_nxt = S_MEM;
                else                        w_state_nxt = S_WB;
            end
            S_MEM: begin
                w_cnt_nxt = w_cnt_inc;
                // ack takes priority over a timeout landing in the same cycle
                if (mem_ack) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_is_lw ? S_WB : S_DONE;
                end else if ((MEM_TIMEOUT != 0) && (w_cnt_inc == TW'(MEM_TIMEOUT))) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_WB:    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_IDLE && instr_valid) r_op <= instr_word[31:26];
        end
    end

    // levels are held from DECODE through DONE for legal opcodes only
    assign w_lvl_en    = (r_state != S_IDLE) && w_legal;
    assign instr_ready = (r_state == S_IDLE);
    assign reg_dst     = w_lvl_en && w_is_r;
    assign alu_src     = w_lvl_en && (w_is_lw || w_is_sw || w_is_addi);
    assign mem_to_reg  = w_lvl_en && w_is_lw;
    assign alu_op      = !w_lvl_en ? 2'd0 : (w_is_r ? 2'd2 : (w_is_beq ? 2'd1 : 2'd0));
    assign branch      = (r_state == S_EXEC) && w_is_beq;
    assign mem_read    = (r_state == S_MEM) && w_is_lw;
    assign mem_write   = (r_state == S_MEM) && w_is_sw;
    assign reg_write   = (r_state == S_WB);
    assign instr_done  = (r_state == S_DONE);
    assign err         = (r_state == S_DONE) && r_err;

`ifdef MIPS_CTRL_PERF_EN
    logic [CNT_W-1:0] r_retired;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (r_state == S_DONE && !r_err && r_retired != {CNT_W{1'b1}}) begin
            r_retired <= r_retired + 1'b1;
        end
    end
    assign retired_count = r_retired;
`else
    assign retired_count = '0;
`endif
endmodule
